// File: rtl/fft_frame_loader.sv
// Ping-pong frame collector for the fftfull load port; frame k+1 fills while frame k is transformed.
// Load data 1 cycle after IDLE pick; no input backpressure, samples arriving with both banks full are dropped (FRAME_LOADER_DROP_CNT_EN adds drop_cnt).
module fft_frame_loader #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9,
    parameter int FFT_SIZE  = 512,
    parameter int DECIM     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    input  logic [BIT_WIDTH-1:0] s_data,
    input  logic                 noted,
    output logic                 fft_load,
    output logic [N-1:0]         add_rd,
    output logic [BIT_WIDTH-1:0] din,
    output logic                 fft_start,
    output logic                 overflow,
`ifdef FRAME_LOADER_DROP_CNT_EN
    output logic [15:0]          drop_cnt,
`endif
    output logic [15:0]          frame_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_START, ST_WAIT} state_t;

    localparam logic [N-1:0] LAST_IDX = N'(FFT_SIZE - 1);
    localparam logic [7:0]   DEC_LAST = 8'(DECIM - 1);

    logic [BIT_WIDTH-1:0] mem [2*FFT_SIZE];

    state_t               state_q, state_d;
    logic                 rd_bank_q, rd_bank_d;
    logic                 fft_load_q, fft_load_d;
    logic [N-1:0]         add_rd_q, add_rd_d;
    logic [BIT_WIDTH-1:0] din_q;
    logic                 fft_start_q, fft_start_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [1:0]           full_q, full_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [N-1:0]         wr_ptr_q, wr_ptr_d;
    logic                 stall_q, stall_d;
    logic [7:0]           dec_cnt_q, dec_cnt_d;
    logic                 accept, release_bank, drop, wr_en, rd_en, other_bank;
    logic [N:0]           rd_addr;

    assign accept       = s_valid && (dec_cnt_q == 8'd0);
    assign release_bank = noted && ((state_q == ST_START) || (state_q == ST_WAIT));
    assign other_bank   = ~wr_bank_q;

    always_comb begin
        dec_cnt_d = dec_cnt_q;
        if (s_valid) begin
            dec_cnt_d = (dec_cnt_q == DEC_LAST) ? 8'd0 : dec_cnt_q + 8'd1;
        end
    end

    // Write side: a release on the same edge as a frame completing still lets the toggle through.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_ptr_d  = wr_ptr_q;
        stall_d   = stall_q;
        wr_en     = 1'b0;
        drop      = 1'b0;
        if (release_bank) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (stall_q) begin
            drop = accept;
            if (release_bank) begin
                stall_d   = 1'b0;
                wr_bank_d = rd_bank_q;
            end
        end else if (accept) begin
            wr_en = 1'b1;
            if (wr_ptr_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_ptr_d          = '0;
                if (!full_q[other_bank] || (release_bank && (rd_bank_q == other_bank))) begin
                    wr_bank_d = other_bank;
                end else begin
                    stall_d = 1'b1;
                end
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
    end

    // While stalled the write bank is the newer full one, so the other bank is always the oldest.
    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        fft_load_d  = 1'b0;
        add_rd_d    = '0;
        fft_start_d = fft_start_q;
        frame_cnt_d = frame_cnt_q;
        rd_en       = 1'b0;
        rd_addr     = '0;
        case (state_q)
            ST_IDLE: begin
                if (full_q != 2'b00) begin
                    rd_bank_d  = full_q[other_bank] ? other_bank : wr_bank_q;
                    rd_en      = 1'b1;
                    rd_addr    = {rd_bank_d, {N{1'b0}}};
                    fft_load_d = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (add_rd_q == LAST_IDX) begin
                    fft_start_d = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_START;
                end else begin
                    fft_load_d = 1'b1;
                    add_rd_d   = add_rd_q + 1'b1;
                    rd_en      = 1'b1;
                    rd_addr    = {rd_bank_q, add_rd_d};
                end
            end
            ST_START, ST_WAIT: begin
                if (noted) begin
                    fft_start_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_bank_q   <= 1'b0;
            fft_load_q  <= 1'b0;
            add_rd_q    <= '0;
            fft_start_q <= 1'b0;
            frame_cnt_q <= '0;
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            stall_q     <= 1'b0;
            dec_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            fft_load_q  <= fft_load_d;
            add_rd_q    <= add_rd_d;
            fft_start_q <= fft_start_d;
            frame_cnt_q <= frame_cnt_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            stall_q     <= stall_d;
            dec_cnt_q   <= dec_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_q, wr_ptr_q}] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            din_q <= '0;
        end else if (rd_en) begin
            din_q <= mem[rd_addr];
        end
    end

`ifdef FRAME_LOADER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    assign drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
    assign drop_cnt = drop_cnt_q;
    assign overflow = (drop_cnt_q != 16'd0);
`else
    logic overflow_q, overflow_d;
    assign overflow_d = overflow_q | drop;
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end
    assign overflow = overflow_q;
`endif

    assign fft_load  = fft_load_q;
    assign add_rd    = add_rd_q;
    assign din       = din_q;
    assign fft_start = fft_start_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: directed scenarios plus a random stream scored against a frame-level queue model.
module tb_fft_frame_loader;

    localparam int BW = 16;
    localparam int NW = 4;
    localparam int FS = 16;
    localparam int TB_DECIM = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1, s_valid = 1'b0, noted = 1'b0, s_valid3 = 1'b0, noted3 = 1'b0;
    logic [BW-1:0] s_data = '0;
    logic          fft_load, fft_start, overflow, fft_load3, fft_start3, overflow3;
    logic [NW-1:0] add_rd, add_rd3;
    logic [BW-1:0] din, din3;
    logic [15:0]   frame_cnt, frame_cnt3;
`ifdef FRAME_LOADER_DROP_CNT_EN
    logic [15:0]   drop_cnt, drop_cnt3;
`endif

    fft_frame_loader #(.BIT_WIDTH(BW), .N(NW), .FFT_SIZE(FS), .DECIM(1)) u_dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .noted(noted),
        .fft_load(fft_load), .add_rd(add_rd), .din(din), .fft_start(fft_start), .overflow(overflow),
`ifdef FRAME_LOADER_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .frame_cnt(frame_cnt));

    fft_frame_loader #(.BIT_WIDTH(BW), .N(NW), .FFT_SIZE(FS), .DECIM(3)) u_dut3 (
        .clk(clk), .reset(reset), .s_valid(s_valid3), .s_data(s_data), .noted(noted3),
        .fft_load(fft_load3), .add_rd(add_rd3), .din(din3), .fft_start(fft_start3), .overflow(overflow3),
`ifdef FRAME_LOADER_DROP_CNT_EN
        .drop_cnt(drop_cnt3),
`endif
        .frame_cnt(frame_cnt3));

    int n_vec = 0, n_err = 0;

    // Reference model: frames in completion order, at most two banks' worth held.
    int            vcnt, pending, drops, frames;
    bit            stalled;
    logic [15:0]   cur[$];
    logic [15:0]   fq[$];

    int run_len, loads_done, dec_next, dec_len, start_age, auto_tgt, auto_fix;
    bit auto_en = 0, auto_rand = 0, stray_en = 0, rst_req = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        vcnt = 0; pending = 0; drops = 0; frames = 0; stalled = 0;
        cur.delete(); fq.delete();
        run_len = 0; loads_done = 0; dec_next = 0; dec_len = 0; start_age = 0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] d, input logic n, input logic fs);
        bit acc, comp;
        acc = 0; comp = 0;
        if (v) begin
            acc = ((vcnt % TB_DECIM) == 0);
            vcnt++;
        end
        if (acc) begin
            if (stalled) drops++;
            else begin
                cur.push_back(d);
                comp = (cur.size() == FS);
            end
        end
        if (n && fs) begin
            pending--;
            stalled = 0;
        end
        if (comp) begin
            for (int i = 0; i < FS; i++) fq.push_back(cur[i]);
            cur.delete();
            pending++;
            frames++;
            if (pending == 2) stalled = 1;
        end
    endtask

    task automatic monitor();
        logic [31:0] e;
        if (fft_load) begin
            chk("add_rd", {28'd0, add_rd}, run_len);
            e = 32'hFFFF_FFFF;
            if (fq.size() > 0) e = {16'd0, fq.pop_front()};
            chk("din", {16'd0, din}, e);
            run_len++;
        end else if (run_len > 0) begin
            chk("load_len", run_len, FS);
            run_len = 0;
            loads_done++;
        end
        if (fft_load3) begin
            chk("dec_din", {16'd0, din3}, dec_next);
            chk("dec_add", {28'd0, add_rd3}, dec_len);
            dec_next += 3;
            dec_len++;
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] d, input logic n, input logic v3);
        logic nt;
        @(negedge clk);
        monitor();
        nt = n;
        if (fft_start) start_age++; else start_age = 0;
        if (auto_en && fft_start && start_age == auto_tgt + 1) nt = 1'b1;
        if (stray_en && !fft_start && $urandom_range(0, 19) == 0) nt = 1'b1;
        reset = rst_req; s_valid = v; s_data = d; noted = nt; s_valid3 = v3;
        if (!rst_req) model_step(v, d, nt, fft_start);
        if (nt && fft_start) auto_tgt = auto_rand ? int'($urandom_range(0, 25)) : auto_fix;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_req = 1;
        cyc(0, 16'd0, 0, 0);
        clear_all();
        repeat (cycles - 1) cyc(0, 16'd0, 0, 0);
        rst_req = 0;
    endtask

    task automatic stream(input int first, input int count, input int gap);
        for (int i = 0; i < count; i++) begin
            cyc(1, 16'(first + i), 0, 0);
            repeat (gap) cyc(0, 16'd0, 0, 0);
        end
    endtask

    task automatic wait_start(input int budget);
        int c = 0;
        while (!fft_start && c < budget) begin
            cyc(0, 16'd0, 0, 0);
            c++;
        end
        chk("wait_start", fft_start, 1);
    endtask

    task automatic drain(input int budget);
        int c = 0;
        auto_en = 1;
        while (!(fq.size() == 0 && !fft_start && !fft_load) && c < budget) begin
            cyc(0, 16'd0, 0, 0);
            c++;
        end
        chk("drain", {fft_load, fft_start, fq.size() == 0}, 3'b001);
    endtask

    initial begin
        clear_all();
        auto_tgt = 4; auto_fix = 4;

        // Reset state
        do_reset(3);
        chk("rst_load", fft_load, 0);
        chk("rst_add", add_rd, 0);
        chk("rst_din", din, 0);
        chk("rst_start", fft_start, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_fcnt", frame_cnt, 0);

        // Single frame, noted after 20 cycles
        stream(0, 16, 0);
        wait_start(40);
        chk("sf_fcnt", frame_cnt, 1);
        repeat (19) cyc(0, 16'd0, 0, 0);
        chk("sf_loads", loads_done, 1);
        chk("sf_hold", fft_start, 1);
        cyc(0, 16'd0, 1, 0);
        chk("sf_clr", fft_start, 0);
        cyc(0, 16'd0, 0, 0);
        chk("sf_idle_load", fft_load, 0);
        chk("sf_idle_add", add_rd, 0);

        // Ping-pong at half rate, noted 5 cycles into each start
        do_reset(2);
        auto_en = 1; auto_rand = 0; auto_fix = 4; auto_tgt = 4;
        stream(0, 48, 1);
        drain(400);
        chk("pp_fcnt", frame_cnt, 3);
        chk("pp_ovf", overflow, 0);
        chk("pp_loads", loads_done, 3);

        // Overflow with noted withheld
        do_reset(2);
        auto_en = 0;
        stream(0, 64, 0);
        chk("ov_flag", overflow, 1);
        chk("ov_model", overflow, drops != 0);
        chk("ov_wait", fft_start, 1);
`ifdef FRAME_LOADER_DROP_CNT_EN
        chk("ov_dcnt", drop_cnt, 32);
`endif
        cyc(0, 16'd0, 1, 0);
        auto_fix = 2; auto_tgt = 2;
        drain(200);
        chk("ov_fcnt", frame_cnt, 2);
        chk("ov_sticky", overflow, 1);
        chk("ov_loads", loads_done, 2);

        // Decimation by 3 on the second instance
        do_reset(2);
        for (int i = 0; i < 48; i++) cyc(0, 16'(i), 0, 1);
        for (int c = 0; c < 40 && !fft_start3; c++) cyc(0, 16'd0, 0, 0);
        chk("dec_start", fft_start3, 1);
        chk("dec_len", dec_len, 16);
        chk("dec_fcnt", frame_cnt3, 1);
        chk("dec_ovf", overflow3, 0);
`ifdef FRAME_LOADER_DROP_CNT_EN
        chk("dec_dcnt", drop_cnt3, 0);
`endif

        // Reset mid-load at add_rd=7
        do_reset(2);
        auto_en = 0;
        stream(0, 16, 0);
        for (int c = 0; c < 40 && !(fft_load && add_rd == 4'd7); c++) cyc(0, 16'd0, 0, 0);
        chk("ml_add", add_rd, 7);
        do_reset(1);
        chk("ml_load", fft_load, 0);
        chk("ml_start", fft_start, 0);
        chk("ml_fcnt", frame_cnt, 0);
        chk("ml_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) cyc(1, 16'($urandom), 0, 0);
        wait_start(40);
        cyc(0, 16'd0, 0, 0);
        chk("ml_fcnt2", frame_cnt, 1);
        chk("ml_loads", loads_done, 1);
        cyc(0, 16'd0, 1, 0);
        chk("ml_clr", fft_start, 0);

        // Release on the same edge as the second bank's last write
        do_reset(2);
        auto_en = 0;
        stream(0, 16, 0);
        wait_start(40);
        stream(16, 15, 0);
        cyc(1, 16'd31, 1, 0);
        auto_en = 1; auto_fix = 3; auto_tgt = 3;
        stream(32, 16, 0);
        drain(300);
        chk("sim_ovf", overflow, 0);
        chk("sim_fcnt", frame_cnt, 3);
        chk("sim_loads", loads_done, 3);
`ifdef FRAME_LOADER_DROP_CNT_EN
        chk("sim_dcnt", drop_cnt, 0);
`endif

        // Random stream at three densities with random noted timing and stray pulses
        do_reset(2);
        auto_en = 1; auto_rand = 1; stray_en = 1;
        auto_tgt = int'($urandom_range(0, 25));
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 600; i++) begin
                int dens;
                dens = (ph == 0) ? 100 : (ph == 1) ? 50 : 25;
                cyc($urandom_range(0, 99) < dens, 16'($urandom), 0, 0);
            end
        end
        stray_en = 0;
        drain(600);
        chk("rnd_ovf", overflow, drops != 0);
        chk("rnd_fcnt", frame_cnt, 16'(frames));
`ifdef FRAME_LOADER_DROP_CNT_EN
        chk("rnd_dcnt", drop_cnt, drops);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
